// File: rtl/alu_muldiv_seq_pkg.sv
// Shared ALU encodings plus the MLT/DIV sequencer opcodes and state type.
package alu_muldiv_seq_pkg;

   typedef enum logic [4:0] {
      ALU_NOP = 5'd0,
      ALU_ADD = 5'd1,
      ALU_SUB = 5'd2,
      ALU_AND = 5'd3,
      ALU_OR  = 5'd4,
      ALU_XOR = 5'd5
   } alu_op_e;

   // Bit positions inside the 6-bit flag vector
   localparam int ALU_FLAG_Z  = 0;
   localparam int ALU_FLAG_CY = 1;
   localparam int ALU_FLAG_V  = 2;
   localparam int ALU_FLAG_S  = 3;
   localparam int ALU_FLAG_AC = 4;
   localparam int ALU_FLAG_P  = 5;
   localparam int ALU_FLAG_W  = 6;

   localparam logic MULDIV_MLT = 1'b0;
   localparam logic MULDIV_DIV = 1'b1;

   typedef enum logic [1:0] {
      SEQ_IDLE  = 2'd0,
      SEQ_CHECK = 2'd1,
      SEQ_ITER  = 2'd2,
      SEQ_DONE  = 2'd3
   } seq_state_e;

   function automatic logic [ALU_FLAG_W-1:0] mk_flags(input logic z, input logic s,
                                                      input logic v, input logic cy);
      logic [ALU_FLAG_W-1:0] f;
      f              = '0;
      f[ALU_FLAG_Z]  = z;
      f[ALU_FLAG_S]  = s;
      f[ALU_FLAG_V]  = v;
      f[ALU_FLAG_CY] = cy;
      return f;
   endfunction

endpackage

// File: rtl/alu_muldiv_seq_if.sv
// Core-side request/response and shared-ALU borrow bus of the MLT/DIV sequencer.
interface alu_muldiv_seq_if;
   import alu_muldiv_seq_pkg::*;

   logic                  start;
   logic                  op;
   logic [15:0]           hl_in;
   logic [7:0]            a_in;
   logic                  busy;
   logic                  done;
   logic [15:0]           result;
   logic [ALU_FLAG_W-1:0] flags_out;
   logic                  div_zero;
   logic                  alu_own;
   logic [4:0]            alu_op;
   logic                  alu_size;
   logic [15:0]           alu_a;
   logic [15:0]           alu_b;
   logic [15:0]           alu_r;
   logic [ALU_FLAG_W-1:0] alu_flags;

   modport master (
      output start, op, hl_in, a_in, alu_r, alu_flags,
      input  busy, done, result, flags_out, div_zero,
             alu_own, alu_op, alu_size, alu_a, alu_b
   );

   modport slave (
      input  start, op, hl_in, a_in, alu_r, alu_flags,
      output busy, done, result, flags_out, div_zero,
             alu_own, alu_op, alu_size, alu_a, alu_b
   );
endinterface

// File: rtl/alu.sv
// Shared combinational ALU: r = b op a, byte (size=0) or word (size=1); CY is borrow on SUB.
module alu
   import alu_muldiv_seq_pkg::*;
(
   input  logic [4:0]            op,
   input  logic                  size,
   input  logic [15:0]           a,
   input  logic [15:0]           b,
   output logic [15:0]           r,
   output logic [ALU_FLAG_W-1:0] flags
);

   logic [16:0] w;
   logic [8:0]  bt;
   logic        cy, msb, am, bm, v;

   always_comb begin
      w  = {1'b0, b};
      bt = {1'b0, b[7:0]};
      case (op)
         ALU_ADD: begin w = {1'b0, b} + {1'b0, a}; bt = {1'b0, b[7:0]} + {1'b0, a[7:0]}; end
         ALU_SUB: begin w = {1'b0, b} - {1'b0, a}; bt = {1'b0, b[7:0]} - {1'b0, a[7:0]}; end
         ALU_AND: begin w = {1'b0, b & a}; bt = {1'b0, b[7:0] & a[7:0]}; end
         ALU_OR:  begin w = {1'b0, b | a}; bt = {1'b0, b[7:0] | a[7:0]}; end
         ALU_XOR: begin w = {1'b0, b ^ a}; bt = {1'b0, b[7:0] ^ a[7:0]}; end
         default: ;
      endcase

      if (size) begin
         r = w[15:0];  cy = w[16];  msb = w[15];  am = a[15];  bm = b[15];
      end else begin
         r = {8'h00, bt[7:0]};  cy = bt[8];  msb = bt[7];  am = a[7];  bm = b[7];
      end

      // Signed overflow: operand signs that should have preserved the result sign did not
      v = 1'b0;
      if (op == ALU_ADD) v = (am == bm) && (msb != bm);
      if (op == ALU_SUB) v = (am != bm) && (msb != bm);

      flags              = '0;
      flags[ALU_FLAG_Z]  = (r == 16'h0000);
      flags[ALU_FLAG_CY] = cy;
      flags[ALU_FLAG_V]  = v;
      flags[ALU_FLAG_S]  = msb;
      flags[ALU_FLAG_P]  = ~^r[7:0];
   end

endmodule

// File: rtl/alu_muldiv_seq.sv
// S1C88 MLT/DIV sequencer: borrows the shared ALU one step per cycle
// (ADD for shift-and-add multiply, SUB for restoring divide).
module alu_muldiv_seq
   import alu_muldiv_seq_pkg::*;
#(
   parameter bit EARLY_EXIT = 1'b0
) (
   input  logic             clk,
   input  logic             reset_n,
   alu_muldiv_seq_if.slave  bus
);

   seq_state_e            state, nstate;
   logic [15:0]           hl_q;
   logic [7:0]            a_q;
   logic                  op_q;
   logic [2:0]            i_q;
   logic [15:0]           acc, rem;
   logic [7:0]            quot;
   logic [15:0]           result_q;
   logic [ALU_FLAG_W-1:0] flags_q;
   logic                  dz_q;

   logic [15:0] a_word;
   logic        no_borrow, div_err, mlt_last;
   logic [7:0]  quot_nx;
   logic [15:0] rem_nx;
   logic        flags_unused;

   assign a_word    = {8'h00, a_q};
   assign no_borrow = !bus.alu_flags[ALU_FLAG_CY];
   assign div_err   = (a_q == 8'h00) || no_borrow;
   // Early exit: no multiplier bits left above the current one
   assign mlt_last  = (i_q == 3'd7) ||
                      (EARLY_EXIT && ((hl_q[7:0] >> ({1'b0, i_q} + 4'd1)) == 8'h00));
   assign quot_nx   = quot | (no_borrow ? (8'h01 << i_q) : 8'h00);
   assign rem_nx    = no_borrow ? bus.alu_r : rem;
   assign flags_unused = ^{bus.alu_flags[ALU_FLAG_W-1:ALU_FLAG_V], bus.alu_flags[ALU_FLAG_Z]};

   always_ff @(posedge clk) begin
      if (!reset_n) state <= SEQ_IDLE;
      else          state <= nstate;
   end

   always_comb begin
      nstate = state;
      case (state)
         SEQ_IDLE:  if (bus.start) nstate = (bus.op == MULDIV_DIV) ? SEQ_CHECK : SEQ_ITER;
         SEQ_CHECK: nstate = div_err ? SEQ_DONE : SEQ_ITER;
         SEQ_ITER: begin
            if (op_q == MULDIV_MLT) nstate = mlt_last ? SEQ_DONE : SEQ_ITER;
            else                    nstate = (i_q == 3'd0) ? SEQ_DONE : SEQ_ITER;
         end
         SEQ_DONE:  nstate = SEQ_IDLE;
         default:   nstate = SEQ_IDLE;
      endcase
   end

   always_comb begin
      bus.busy     = (state != SEQ_IDLE);
      bus.done     = (state == SEQ_DONE);
      bus.alu_own  = 1'b0;
      bus.alu_op   = ALU_NOP;
      bus.alu_size = 1'b0;
      bus.alu_a    = 16'h0000;
      bus.alu_b    = 16'h0000;
      case (state)
         SEQ_CHECK: begin
            // Byte compare H - D: no borrow means the quotient would not fit in 8 bits
            bus.alu_own = 1'b1;
            bus.alu_op  = ALU_SUB;
            bus.alu_b   = {8'h00, hl_q[15:8]};
            bus.alu_a   = a_word;
         end
         SEQ_ITER: begin
            bus.alu_own  = 1'b1;
            bus.alu_size = 1'b1;
            if (op_q == MULDIV_MLT) begin
               bus.alu_op = ALU_ADD;
               bus.alu_b  = acc;
               bus.alu_a  = hl_q[i_q] ? (a_word << i_q) : 16'h0000;
            end else begin
               bus.alu_op = ALU_SUB;
               bus.alu_b  = rem;
               bus.alu_a  = a_word << i_q;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         hl_q     <= '0;
         a_q      <= '0;
         op_q     <= 1'b0;
         i_q      <= '0;
         acc      <= '0;
         rem      <= '0;
         quot     <= '0;
         result_q <= '0;
         flags_q  <= '0;
         dz_q     <= 1'b0;
      end else begin
         case (state)
            SEQ_IDLE: if (bus.start) begin
               hl_q <= bus.hl_in;
               a_q  <= bus.a_in;
               op_q <= bus.op;
               i_q  <= (bus.op == MULDIV_DIV) ? 3'd7 : 3'd0;
               acc  <= '0;
               rem  <= '0;
               quot <= '0;
            end
            SEQ_CHECK: begin
               if (div_err) begin
                  result_q <= hl_q;
                  flags_q  <= mk_flags(1'b0, 1'b0, a_q != 8'h00, 1'b0);
                  dz_q     <= (a_q == 8'h00);
               end else begin
                  rem <= hl_q;
               end
            end
            SEQ_ITER: begin
               if (op_q == MULDIV_MLT) begin
                  acc <= bus.alu_r;
                  i_q <= i_q + 3'd1;
                  if (mlt_last) begin
                     result_q <= bus.alu_r;
                     flags_q  <= mk_flags(bus.alu_r == 16'h0000, bus.alu_r[15], 1'b0, 1'b0);
                     dz_q     <= 1'b0;
                  end
               end else begin
                  rem  <= rem_nx;
                  quot <= quot_nx;
                  i_q  <= i_q - 3'd1;
                  if (i_q == 3'd0) begin
                     result_q <= {rem_nx[7:0], quot_nx};
                     flags_q  <= mk_flags(quot_nx == 8'h00, quot_nx[7], 1'b0, 1'b0);
                     dz_q     <= 1'b0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.result    = result_q;
   assign bus.flags_out = flags_q;
   assign bus.div_zero  = dz_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Bench: two sequencers (EARLY_EXIT=0/1) each paired with an alu, sharing one stimulus.
module tb_alu_muldiv_seq;
   import alu_muldiv_seq_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        op = 1'b0;
   logic [15:0] hl = 16'h0000;
   logic [7:0]  a = 8'h00;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   alu_muldiv_seq_if bus0 ();
   alu_muldiv_seq_if bus1 ();

   assign bus0.start = start;  assign bus0.op = op;  assign bus0.hl_in = hl;  assign bus0.a_in = a;
   assign bus1.start = start;  assign bus1.op = op;  assign bus1.hl_in = hl;  assign bus1.a_in = a;

   alu u_alu0 (.op(bus0.alu_op), .size(bus0.alu_size), .a(bus0.alu_a), .b(bus0.alu_b),
               .r(bus0.alu_r), .flags(bus0.alu_flags));
   alu u_alu1 (.op(bus1.alu_op), .size(bus1.alu_size), .a(bus1.alu_a), .b(bus1.alu_b),
               .r(bus1.alu_r), .flags(bus1.alu_flags));

   alu_muldiv_seq #(.EARLY_EXIT(1'b0)) dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0.slave));
   alu_muldiv_seq #(.EARLY_EXIT(1'b1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1.slave));

   typedef struct {
      logic        op;
      logic [15:0] hl;
      logic [7:0]  a;
      logic [15:0] res;
      logic [5:0]  fl;
      bit          dz;
      int          l0;
      int          l1;
   } vec_t;

   vec_t vecs[9];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic logic [5:0] fz(input bit z, input bit s, input bit v);
      logic [5:0] f;
      f = '0;
      f[ALU_FLAG_Z] = z;
      f[ALU_FLAG_S] = s;
      f[ALU_FLAG_V] = v;
      return f;
   endfunction

   // Reference: plain integer multiply/divide, latency from the op's cycle budget
   function automatic void model(input logic o, input logic [15:0] h, input logic [7:0] d,
                                 output logic [15:0] res, output logic [5:0] fl,
                                 output bit dz, output int l0, output int l1);
      int p, q, r, top;
      dz = 1'b0;
      if (o == MULDIV_MLT) begin
         p   = int'(h[7:0]) * int'(d);
         res = p[15:0];
         fl  = fz(res == 16'h0, res[15], 1'b0);
         top = 0;
         for (int k = 0; k < 8; k++) if (h[k]) top = k;
         l0 = 9;
         l1 = 2 + top;
      end else if (d == 8'h00) begin
         res = h; fl = fz(0, 0, 0); dz = 1'b1; l0 = 2; l1 = 2;
      end else if (h[15:8] >= d) begin
         res = h; fl = fz(0, 0, 1); l0 = 2; l1 = 2;
      end else begin
         q   = int'(h) / int'(d);
         r   = int'(h) % int'(d);
         res = {r[7:0], q[7:0]};
         fl  = fz(q == 0, q[7], 1'b0);
         l0 = 10; l1 = 10;
      end
   endfunction

   // Launch one op; returns in the IDLE cycle after dut0's DONE so the next call is back-to-back
   task automatic run_op(input logic o, input logic [15:0] h, input logic [7:0] d,
                         input logic [15:0] er, input logic [5:0] ef, input bit edz,
                         input int l0, input int l1, input bit noise, input string tag);
      int d0n = 0, d1n = 0, dc0 = 0, dc1 = 0, busy_c = 0, own_c = 0, idle_bad = 0;
      logic [15:0] r0 = '0, r1 = '0;
      logic [5:0]  f0 = '0;
      logic        z0 = 1'b0;
      op = o; hl = h; a = d; start = 1'b1;
      for (int n = 1; n <= 14; n++) begin
         step();
         start = 1'b0;
         if (noise && n == 3) begin
            start = 1'b1; op = ~o; hl = 16'($urandom); a = 8'($urandom);
         end
         if (bus0.busy) busy_c++;
         if (bus0.alu_own) own_c++;
         else if (bus0.alu_op != 5'd0 || bus0.alu_size || bus0.alu_a != 16'h0 || bus0.alu_b != 16'h0)
            idle_bad++;
         if (bus0.done) begin
            dc0++;
            if (d0n == 0) begin d0n = n; r0 = bus0.result; f0 = bus0.flags_out; z0 = bus0.div_zero; end
         end
         if (bus1.done) begin
            dc1++;
            if (d1n == 0) begin d1n = n; r1 = bus1.result; end
         end
         if (d0n != 0 && n > d0n) break;
      end
      chk({tag, ".lat"},     d0n, l0);
      chk({tag, ".lat_ee"},  d1n, l1);
      chk({tag, ".result"},  r0, er);
      chk({tag, ".res_ee"},  r1, er);
      chk({tag, ".flags"},   f0, ef);
      chk({tag, ".divzero"}, z0, edz);
      chk({tag, ".busy"},    busy_c, l0);
      chk({tag, ".own"},     own_c, l0 - 1);
      chk({tag, ".pulse"},   dc0, 1);
      chk({tag, ".pulse_ee"}, dc1, 1);
      chk({tag, ".alu_idle"}, idle_bad, 0);
   endtask

   initial begin
      logic [15:0] er;
      logic [5:0]  ef;
      bit          edz;
      int          l0, l1, dn;
      logic        o;
      logic [15:0] h;
      logic [7:0]  d;

      vecs[0] = '{MULDIV_MLT, 16'h00FF, 8'hFF, 16'hFE01, fz(0, 1, 0), 1'b0, 9, 9};
      vecs[1] = '{MULDIV_MLT, 16'hAB00, 8'h37, 16'h0000, fz(1, 0, 0), 1'b0, 9, 2};
      vecs[2] = '{MULDIV_DIV, 16'h1234, 8'h56, 16'h1036, fz(0, 0, 0), 1'b0, 10, 10};
      vecs[3] = '{MULDIV_DIV, 16'h1234, 8'h00, 16'h1234, fz(0, 0, 0), 1'b1, 2, 2};
      vecs[4] = '{MULDIV_DIV, 16'h5600, 8'h56, 16'h5600, fz(0, 0, 1), 1'b0, 2, 2};
      vecs[5] = '{MULDIV_MLT, 16'h0001, 8'h80, 16'h0080, fz(0, 0, 0), 1'b0, 9, 2};
      vecs[6] = '{MULDIV_DIV, 16'h0000, 8'h01, 16'h0000, fz(1, 0, 0), 1'b0, 10, 10};
      vecs[7] = '{MULDIV_DIV, 16'hFEFF, 8'hFF, 16'hFEFF, fz(0, 1, 0), 1'b0, 10, 10};
      vecs[8] = '{MULDIV_MLT, 16'h0010, 8'h03, 16'h0030, fz(0, 0, 0), 1'b0, 9, 6};

      reset_n = 1'b0;
      repeat (3) step();
      chk("rst.busy",    bus0.busy, 0);
      chk("rst.done",    bus0.done, 0);
      chk("rst.own",     bus0.alu_own, 0);
      chk("rst.alu_op",  bus0.alu_op, 0);
      chk("rst.result",  bus0.result, 0);
      chk("rst.flags",   bus0.flags_out, 0);
      chk("rst.divzero", bus0.div_zero, 0);
      chk("rst.busy_ee", bus1.busy, 0);
      reset_n = 1'b1;

      foreach (vecs[k])
         run_op(vecs[k].op, vecs[k].hl, vecs[k].a, vecs[k].res, vecs[k].fl, vecs[k].dz,
                vecs[k].l0, vecs[k].l1, 1'b0, $sformatf("vec%0d", k));

      for (int k = 0; k < 40; k++) begin
         o = 1'($urandom_range(0, 1));
         d = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 9) == 0) d = 8'h00;
         h = 16'($urandom);
         if (o == MULDIV_DIV && d != 8'h00 && $urandom_range(0, 3) != 0)
            h[15:8] = 8'($urandom_range(0, int'(d) - 1));
         model(o, h, d, er, ef, edz, l0, l1);
         run_op(o, h, d, er, ef, edz, l0, l1, 1'b0, $sformatf("rnd%0d", k));
      end

      // start pulses while busy must not disturb the running op
      run_op(MULDIV_MLT, 16'h00FF, 8'hFF, 16'hFE01, fz(0, 1, 0), 1'b0, 9, 9, 1'b1, "ignore_start");

      // Reset mid-DIV: idle next cycle, outputs cleared, no done pulse afterwards
      op = MULDIV_DIV; hl = 16'h1234; a = 8'h56; start = 1'b1;
      for (int n = 1; n <= 4; n++) begin
         step();
         start = 1'b0;
      end
      reset_n = 1'b0;
      step();
      chk("midrst.busy",    bus0.busy, 0);
      chk("midrst.own",     bus0.alu_own, 0);
      chk("midrst.done",    bus0.done, 0);
      chk("midrst.result",  bus0.result, 0);
      chk("midrst.flags",   bus0.flags_out, 0);
      chk("midrst.busy_ee", bus1.busy, 0);
      reset_n = 1'b1;
      dn = 0;
      for (int n = 0; n < 12; n++) begin
         step();
         if (bus0.done || bus1.done || bus0.busy) dn++;
      end
      chk("midrst.no_done", dn, 0);

      run_op(MULDIV_DIV, 16'h1234, 8'h56, 16'h1036, fz(0, 0, 0), 1'b0, 10, 10, 1'b0, "post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
